// File: rtl/multi_dataflow_job_sequencer.sv
// multi_dataflow_job_sequencer: job-level controller that arms streamers, launches the engine,
// counts output beats, waits for sink drain and guards the job with a stall watchdog.
module multi_dataflow_job_sequencer #(
   parameter int LEN_W   = 16,
   parameter int TO_W    = 12,
   parameter int TIMEOUT = 4095
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             src_ready_i,
   input  logic             sink_ready_i,
   input  logic             sink_done_i,
   input  logic             out_hs_i,
   output logic             src_start_o,
   output logic             sink_start_o,
   output logic             engine_start_o,
   output logic             engine_clear_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] beat_cnt_o
);
   typedef enum logic [2:0] {IDLE, ARM, LAUNCH, RUN, DRAIN, DONE, ERR} state_e;
   state_e state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic last, timeout;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         len_q   <= '0;
         beat_q  <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         wd_q    <= wd_d;
      end
   end
   // last: this handshake completes the job; timeout: this idle cycle is the TIMEOUT-th
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      beat_d  = beat_q;
      wd_d    = wd_q;
      last    = beat_q == len_q - LEN_W'(1);
      timeout = wd_q == TO_W'(TIMEOUT - 1);
      if (clear_i) begin
         state_d = IDLE;
         beat_d  = '0;
         wd_d    = '0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               len_d   = len_i;
               beat_d  = '0;
               state_d = (len_i != '0) ? ARM : DONE;
            end
            ARM: state_d = (src_ready_i && sink_ready_i) ? LAUNCH : ARM;
            LAUNCH: begin
               wd_d    = '0;
               beat_d  = out_hs_i ? beat_q + LEN_W'(1) : beat_q;
               state_d = (out_hs_i && last) ? DRAIN : RUN;
            end
            RUN: if (out_hs_i) begin
               beat_d  = beat_q + LEN_W'(1);
               wd_d    = '0;
               state_d = last ? DRAIN : RUN;
            end else begin
               wd_d    = wd_q + TO_W'(1);
               state_d = timeout ? ERR : RUN;
            end
            DRAIN: if (sink_done_i) begin
               wd_d    = '0;
               state_d = DONE;
            end else begin
               wd_d    = wd_q + TO_W'(1);
               state_d = timeout ? ERR : DRAIN;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
         endcase
      end
   end
   assign src_start_o    = (state_q == LAUNCH) && !clear_i;
   assign sink_start_o   = (state_q == LAUNCH) && !clear_i;
   assign engine_start_o = (state_q == LAUNCH) && !clear_i;
   assign done_o         = (state_q == DONE) && !clear_i;
   assign engine_clear_o = clear_i || ((state_q == IDLE) && start_i && (len_i != '0));
   assign busy_o         = state_q inside {ARM, LAUNCH, RUN, DRAIN};
   assign err_o          = state_q == ERR;
   assign beat_cnt_o     = beat_q;
endmodule

// File: tb/tb_multi_dataflow_job_sequencer.sv
// tb_multi_dataflow_job_sequencer: directed checks of nominal, zero-length, backpressure,
// watchdog, mid-job clear and corner cases with a shortened watchdog.
module tb_multi_dataflow_job_sequencer;
   logic clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
   logic [15:0] len_i = '0;
   logic src_ready_i = 1'b0, sink_ready_i = 1'b0, sink_done_i = 1'b0, out_hs_i = 1'b0;
   logic src_start_o, sink_start_o, engine_start_o, engine_clear_o, busy_o, done_o, err_o;
   logic [15:0] beat_cnt_o;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   multi_dataflow_job_sequencer #(.LEN_W(16), .TO_W(12), .TIMEOUT(16)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
      .src_ready_i(src_ready_i), .sink_ready_i(sink_ready_i), .sink_done_i(sink_done_i),
      .out_hs_i(out_hs_i), .src_start_o(src_start_o), .sink_start_o(sink_start_o),
      .engine_start_o(engine_start_o), .engine_clear_o(engine_clear_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o), .beat_cnt_o(beat_cnt_o)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic starts(input string tag, input logic exp);
      chk({tag, "_src"}, src_start_o, exp);
      chk({tag, "_sink"}, sink_start_o, exp);
      chk({tag, "_eng"}, engine_start_o, exp);
   endtask
   initial begin
      #12;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_beat", beat_cnt_o, 0);
      starts("rst", 0);
      chk("rst_eclr", engine_clear_o, 0);
      rst_ni = 1'b1;
      tick(2);
      // nominal job, len 8
      src_ready_i = 1; sink_ready_i = 1; len_i = 8; start_i = 1;
      #1 chk("t1_eclr", engine_clear_o, 1);
      tick(); start_i = 0;
      chk("t1_arm_busy", busy_o, 1);
      starts("t1_arm", 0);
      tick();
      starts("t1_launch", 1);
      tick();
      starts("t1_run", 0);
      out_hs_i = 1;
      tick(7);
      chk("t1_beat7", beat_cnt_o, 7);
      chk("t1_busy7", busy_o, 1);
      tick();
      chk("t1_beat8", beat_cnt_o, 8);
      tick();
      chk("t1_sat", beat_cnt_o, 8);
      out_hs_i = 0;
      tick(2);
      chk("t1_nodone", done_o, 0);
      sink_done_i = 1;
      tick(); sink_done_i = 0;
      chk("t1_done", done_o, 1);
      chk("t1_done_beat", beat_cnt_o, 8);
      tick();
      chk("t1_done_once", done_o, 0);
      chk("t1_hold_beat", beat_cnt_o, 8);
      chk("t1_idle_busy", busy_o, 0);
      // zero length
      len_i = 0; start_i = 1;
      #1 chk("t2_eclr", engine_clear_o, 0);
      tick(); start_i = 0;
      chk("t2_done", done_o, 1);
      chk("t2_busy", busy_o, 0);
      chk("t2_beat", beat_cnt_o, 0);
      starts("t2", 0);
      tick();
      chk("t2_done_once", done_o, 0);
      chk("t2_busy2", busy_o, 0);
      // backpressure in ARM
      sink_ready_i = 0; len_i = 4; start_i = 1;
      tick(); start_i = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_hold", src_start_o, 0);
      end
      sink_ready_i = 1;
      tick();
      starts("t3_launch", 1);
      tick();
      starts("t3_run", 0);
      out_hs_i = 1;
      tick(4); out_hs_i = 0;
      chk("t3_beat", beat_cnt_o, 4);
      sink_done_i = 1;
      tick(); sink_done_i = 0;
      chk("t3_done", done_o, 1);
      tick();
      // watchdog
      len_i = 4; start_i = 1;
      tick(); start_i = 0;
      tick(2);
      out_hs_i = 1;
      tick(2); out_hs_i = 0;
      chk("t4_beat", beat_cnt_o, 2);
      tick(15);
      chk("t4_noerr", err_o, 0);
      chk("t4_busy", busy_o, 1);
      tick();
      chk("t4_err", err_o, 1);
      chk("t4_err_busy", busy_o, 0);
      len_i = 5; start_i = 1;
      tick(2); start_i = 0;
      chk("t4_sticky", err_o, 1);
      chk("t4_ign_beat", beat_cnt_o, 2);
      starts("t4_ign", 0);
      clear_i = 1;
      #1 chk("t4_clr_eclr", engine_clear_o, 1);
      tick(); clear_i = 0;
      chk("t4_clr_err", err_o, 0);
      chk("t4_clr_busy", busy_o, 0);
      chk("t4_clr_beat", beat_cnt_o, 0);
      // clear mid-job
      len_i = 8; start_i = 1;
      tick(); start_i = 0;
      tick(2);
      out_hs_i = 1;
      tick(3); out_hs_i = 0;
      chk("t5_beat3", beat_cnt_o, 3);
      clear_i = 1;
      tick(); clear_i = 0;
      chk("t5_busy", busy_o, 0);
      chk("t5_beat0", beat_cnt_o, 0);
      chk("t5_nodone", done_o, 0);
      len_i = 2; start_i = 1;
      tick(); start_i = 0;
      tick();
      starts("t5_launch", 1);
      tick();
      out_hs_i = 1;
      tick(2); out_hs_i = 0;
      chk("t5_beat2", beat_cnt_o, 2);
      sink_done_i = 1;
      tick(); sink_done_i = 0;
      chk("t5_done", done_o, 1);
      tick();
      // start while busy ignored, then done vs timeout in the same cycle
      len_i = 3; start_i = 1;
      tick();
      len_i = 9;
      tick(); start_i = 0;
      chk("t6_launch_beat", beat_cnt_o, 0);
      tick();
      out_hs_i = 1;
      tick(3); out_hs_i = 0;
      chk("t6_latched_len", beat_cnt_o, 3);
      tick(15);
      chk("t6_noerr", err_o, 0);
      sink_done_i = 1;
      tick(); sink_done_i = 0;
      chk("t6_race_done", done_o, 1);
      chk("t6_race_err", err_o, 0);
      tick();
      chk("t6_idle_err", err_o, 0);
      // maximum length, no wrap
      len_i = 16'hFFFF; start_i = 1;
      tick(); start_i = 0;
      tick(2);
      out_hs_i = 1;
      tick(65535);
      chk("t6_max_beat", beat_cnt_o, 16'hFFFF);
      chk("t6_max_busy", busy_o, 1);
      tick();
      chk("t6_max_sat", beat_cnt_o, 16'hFFFF);
      out_hs_i = 0;
      sink_done_i = 1;
      tick(); sink_done_i = 0;
      chk("t6_max_done", done_o, 1);
      chk("t6_max_final", beat_cnt_o, 16'hFFFF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
